// File: rtl/sigma_delta_dac_mc.sv
// Multi-channel first-order sigma-delta DAC with atomic sample latching,
// per-channel soft-mute/slew ramp and one 1-bit bitstream per channel.
module sigma_delta_dac_mc #(
  parameter int   CHANNELS  = 2,
  parameter int   MSBI      = 15,
  parameter logic INV       = 1'b1,
  parameter int   SIGNED_IN = 0,
  parameter int   RAMP_DIV  = 64,
  parameter int   RAMP_STEP = 16
) (
  input  logic                           CLK,
  input  logic                           RESET_N,
  input  logic                           STB,
  input  logic [CHANNELS*(MSBI+1)-1:0]   DACin,
  input  logic                           MUTE,
  output logic [CHANNELS-1:0]            DACout,
  output logic                           MUTED
);

  localparam int            W         = MSBI + 1;
  localparam logic [W-1:0]  MID       = W'(1) << MSBI;
  localparam logic [W-1:0]  SIGN_FLIP = (SIGNED_IN != 0) ? MID : '0;
  localparam logic [W:0]    STEP      = (W+1)'(RAMP_STEP);
  localparam int            CW        = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam logic [CW-1:0] LAST      = CW'(RAMP_DIV - 1);

  logic [CW-1:0] tickCount;
  logic          tick;
  logic          allMid;
  logic [W-1:0]  holdReg  [CHANNELS];
  logic [W-1:0]  effLevel [CHANNELS];
  logic [W-1:0]  accReg   [CHANNELS];
  logic [W-1:0]  target   [CHANNELS];
  logic [W-1:0]  effNext  [CHANNELS];
  logic [W:0]    modSum   [CHANNELS];

  // Tick marks the last count of each ramp period
  always_comb begin
    tick = (tickCount == LAST);
  end

  // Free-running ramp divider shared by every channel
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      tickCount <= '0;
    end else if (tick) begin
      tickCount <= '0;
    end else begin
      tickCount <= tickCount + 1'b1;
    end
  end

  // Slew each effective level toward its target without overshoot or wrap
  always_comb begin
    logic [W:0] diff;
    for (int c = 0; c < CHANNELS; c++) begin
      diff       = '0;
      target[c]  = MUTE ? MID : holdReg[c];
      effNext[c] = effLevel[c];
      if (RAMP_STEP == 0) begin
        effNext[c] = target[c];
      end else if (tick) begin
        if (target[c] >= effLevel[c]) begin
          diff = {1'b0, target[c]} - {1'b0, effLevel[c]};
          if (diff <= STEP) effNext[c] = target[c];
          else              effNext[c] = effLevel[c] + STEP[W-1:0];
        end else begin
          diff = {1'b0, effLevel[c]} - {1'b0, target[c]};
          if (diff <= STEP) effNext[c] = target[c];
          else              effNext[c] = effLevel[c] - STEP[W-1:0];
        end
      end
    end
  end

  // Modulator sum and the all-channels-at-midscale flag
  always_comb begin
    allMid = 1'b1;
    for (int c = 0; c < CHANNELS; c++) begin
      modSum[c] = {1'b0, accReg[c]} + {1'b0, effLevel[c]};
      if (effLevel[c] != MID) allMid = 1'b0;
    end
  end

  // Sample hold registers and effective levels
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int c = 0; c < CHANNELS; c++) begin
        holdReg[c]  <= MID;
        effLevel[c] <= MID;
      end
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        if (STB) holdReg[c] <= DACin[c*W +: W] ^ SIGN_FLIP;
        effLevel[c] <= effNext[c];
      end
    end
  end

  // First-order accumulators; the carry is the output bitstream
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int c = 0; c < CHANNELS; c++) accReg[c] <= MID;
      DACout <= {CHANNELS{INV}};
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        accReg[c] <= modSum[c][W-1:0];
        DACout[c] <= modSum[c][W] ^ INV;
      end
    end
  end

  // Muted status, judged on the levels before this clock's update
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      MUTED <= 1'b0;
    end else begin
      MUTED <= MUTE & allMid;
    end
  end

endmodule

// File: tb/tb_sigma_delta_dac_mc.sv
// Bench for sigma_delta_dac_mc: two instances (unsigned/no ramp/INV=0 and
// signed/ramped/INV=1) share stimulus and are checked against a level model.
module tb_sigma_delta_dac_mc;

  localparam int DIV      = 4;
  localparam int STEPV[2] = '{0, 3};
  localparam int INVV[2]  = '{0, 1};
  localparam int SGNV[2]  = '{0, 1};

  logic       CLK = 1'b0;
  logic       RESET_N;
  logic       STB;
  logic       MUTE;
  logic [7:0] DACin;
  logic [1:0] dacA, dacB;
  logic       mutedA, mutedB;

  int errors = 0;
  int checks = 0;

  // Reference model state: levels, running sum of levels, outputs
  int     mHold  [2][2];
  int     mEff   [2][2];
  longint mTotal [2][2];
  int     mCount;
  int     mOut   [2];
  int     mMuted [2];

  sigma_delta_dac_mc #(
    .CHANNELS(2), .MSBI(3), .INV(1'b0), .SIGNED_IN(0), .RAMP_DIV(DIV), .RAMP_STEP(0)
  ) dutA (
    .CLK(CLK), .RESET_N(RESET_N), .STB(STB), .DACin(DACin), .MUTE(MUTE),
    .DACout(dacA), .MUTED(mutedA)
  );

  sigma_delta_dac_mc #(
    .CHANNELS(2), .MSBI(3), .INV(1'b1), .SIGNED_IN(1), .RAMP_DIV(DIV), .RAMP_STEP(3)
  ) dutB (
    .CLK(CLK), .RESET_N(RESET_N), .STB(STB), .DACin(DACin), .MUTE(MUTE),
    .DACout(dacB), .MUTED(mutedB)
  );

  always #5 CLK = ~CLK;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic stb, input logic [7:0] data, input logic mute);
    @(negedge CLK);
    STB   = stb;
    DACin = data;
    MUTE  = mute;
  endtask

  task automatic measure(output int a0, output int a1, output int b0, output int b1);
    a0 = 0; a1 = 0; b0 = 0; b1 = 0;
    repeat (16) begin
      @(negedge CLK);
      a0 += int'(dacA[0]); a1 += int'(dacA[1]);
      b0 += int'(dacB[0]); b1 += int'(dacB[1]);
    end
  endtask

  // Model: output carry = how often the running sum of levels crosses 16
  always @(posedge CLK or negedge RESET_N) begin
    int  tgt, u, carry, bits;
    bit  allMid, tick;
    if (!RESET_N) begin
      mCount = 0;
      for (int i = 0; i < 2; i++) begin
        for (int c = 0; c < 2; c++) begin
          mHold[i][c] = 8; mEff[i][c] = 8; mTotal[i][c] = 8;
        end
        mOut[i]   = INVV[i] ? 3 : 0;
        mMuted[i] = 0;
      end
    end else begin
      tick = (mCount == DIV - 1);
      for (int i = 0; i < 2; i++) begin
        allMid = (mEff[i][0] == 8) && (mEff[i][1] == 8);
        bits = 0;
        for (int c = 0; c < 2; c++) begin
          carry = int'((mTotal[i][c] + mEff[i][c]) / 16 - mTotal[i][c] / 16);
          bits |= (carry ^ INVV[i]) << c;
          mTotal[i][c] += mEff[i][c];
        end
        mOut[i]   = bits;
        mMuted[i] = (MUTE && allMid) ? 1 : 0;
        for (int c = 0; c < 2; c++) begin
          tgt = MUTE ? 8 : mHold[i][c];
          if (STEPV[i] == 0) mEff[i][c] = tgt;
          else if (tick) begin
            if (tgt > mEff[i][c])
              mEff[i][c] = (tgt - mEff[i][c] <= STEPV[i]) ? tgt : mEff[i][c] + STEPV[i];
            else
              mEff[i][c] = (mEff[i][c] - tgt <= STEPV[i]) ? tgt : mEff[i][c] - STEPV[i];
          end
        end
        if (STB) begin
          for (int c = 0; c < 2; c++) begin
            u = int'((DACin >> (4 * c)) & 8'hF);
            if (SGNV[i] != 0) u = u ^ 8;
            mHold[i][c] = u;
          end
        end
      end
      mCount = (mCount + 1) % DIV;
    end
  end

  // Every-cycle comparison of both instances against the model
  always @(negedge CLK) begin
    checkOutput("dacA",   int'(dacA),   mOut[0]);
    checkOutput("dacB",   int'(dacB),   mOut[1]);
    checkOutput("mutedA", int'(mutedA), mMuted[0]);
    checkOutput("mutedB", int'(mutedB), mMuted[1]);
  end

  initial begin
    int a0, a1, b0, b1, last, minSeen;
    int seq[$];
    RESET_N = 1'b0; STB = 1'b0; MUTE = 1'b0; DACin = 8'h00;

    // Reset and idle midscale duty
    repeat (3) @(negedge CLK);
    checkOutput("rst_dacA", int'(dacA), 0);
    checkOutput("rst_dacB", int'(dacB), 3);
    checkOutput("rst_mutedB", int'(mutedB), 0);
    #2 RESET_N = 1'b1;
    repeat (4) @(negedge CLK);
    measure(a0, a1, b0, b1);
    checkOutput("idle_a0", a0, 8); checkOutput("idle_a1", a1, 8);
    checkOutput("idle_b0", b0, 8); checkOutput("idle_b1", b1, 8);

    // Unramped duty: 4 and 15, then zero
    applyStimulus(1'b1, {4'd15, 4'd4}, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0);
    repeat (3) @(negedge CLK);
    measure(a0, a1, b0, b1);
    checkOutput("duty_a0_4", a0, 4); checkOutput("duty_a1_15", a1, 15);
    applyStimulus(1'b1, {4'd15, 4'd0}, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0);
    repeat (3) @(negedge CLK);
    measure(a0, a1, b0, b1);
    checkOutput("duty_a0_0", a0, 0);

    // Signed extremes on the ramped, inverted instance
    applyStimulus(1'b1, {4'b0111, 4'b1000}, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0);
    repeat (20) @(negedge CLK);
    measure(a0, a1, b0, b1);
    checkOutput("signed_b0", b0, 16); checkOutput("signed_b1", b1, 1);
    checkOutput("signed_a0", a0, 8);  checkOutput("signed_a1", a1, 7);

    // Soft mute from 15: levels step 12, 9, 8
    applyStimulus(1'b1, {4'b0111, 4'b0111}, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0);
    repeat (30) @(negedge CLK);
    checkOutput("pre_mute_eff", mEff[1][0], 15);
    last = mEff[1][0];
    applyStimulus(1'b0, 8'h00, 1'b1);
    repeat (20) begin
      @(negedge CLK);
      if (mEff[1][0] != last) begin
        seq.push_back(mEff[1][0]);
        last = mEff[1][0];
      end
    end
    checkOutput("mute_steps", seq.size(), 3);
    if (seq.size() == 3) begin
      checkOutput("mute_step1", seq[0], 12);
      checkOutput("mute_step2", seq[1], 9);
      checkOutput("mute_step3", seq[2], 8);
    end
    checkOutput("muted_a", int'(mutedA), 1);
    checkOutput("muted_b", int'(mutedB), 1);

    // Unmute mid-ramp, then retarget channel 0 to 2
    applyStimulus(1'b0, 8'h00, 1'b0);
    repeat (5) @(negedge CLK);
    applyStimulus(1'b1, {4'b0111, 4'b1010}, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0);
    minSeen = mEff[1][0];
    repeat (24) begin
      @(negedge CLK);
      if (mEff[1][0] < minSeen) minSeen = mEff[1][0];
    end
    checkOutput("retarget_final", mEff[1][0], 2);
    checkOutput("retarget_min", minSeen, 2);
    measure(a0, a1, b0, b1);
    checkOutput("retarget_b0", b0, 14); checkOutput("retarget_b1", b1, 1);

    // Asynchronous reset between clock edges during a ramp
    applyStimulus(1'b1, {4'b1111, 4'b0001}, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0);
    repeat (2) @(negedge CLK);
    @(posedge CLK);
    #2 RESET_N = 1'b0;
    #1;
    checkOutput("arst_dacB", int'(dacB), 3);
    checkOutput("arst_dacA", int'(dacA), 0);
    checkOutput("arst_mutedB", int'(mutedB), 0);
    @(negedge CLK);
    #2 RESET_N = 1'b1;
    repeat (3) @(negedge CLK);
    checkOutput("arst_eff", mEff[1][0], 8);
    measure(a0, a1, b0, b1);
    checkOutput("arst_b0", b0, 8); checkOutput("arst_b1", b1, 8);

    // Randomized traffic with occasional mute changes and resets
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 399) == 0) begin
        @(posedge CLK);
        #2 RESET_N = 1'b0;
        @(negedge CLK);
        #2 RESET_N = 1'b1;
      end
      applyStimulus(($urandom_range(0, 7) == 0), 8'($urandom),
                    ($urandom_range(0, 49) == 0) ? ~MUTE : MUTE);
    end
    applyStimulus(1'b0, 8'h00, 1'b0);
    repeat (2) @(negedge CLK);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sigma_delta_dac_mc.md
# sigma_delta_dac_mc

Multi-channel first-order sigma-delta DAC, the parametrised successor to the single-channel PWM/sigma-delta DAC in the audio output path. It accepts CHANNELS packed samples, in unsigned or signed format, latched atomically on a sample strobe. A per-channel soft-mute/slew ramp prevents clicks. It drives one 1-bit output per channel into the external analog low-pass filters.

## Interface
- CHANNELS, 2: number of independent channels (1..8).
- MSBI, 15: highest sample bit index; sample width W = MSBI+1.
- INV, 1'b1: output polarity; every DACout bit is XORed with INV.
- SIGNED_IN, 0: 1 = two's-complement input (MSB inverted to excess-2^MSBI); 0 = unsigned excess-2^MSBI.
- RAMP_DIV, 64: clocks per ramp tick (>=1).
- RAMP_STEP, 16: maximum change of the effective level per tick; 0 = ramp disabled (E follows T every clock).
- CLK  in  1  system clock; all state on rising edge. One clock; reset is asynchronous and active-low.
- RESET_N  in  1  asynchronous active-low reset.
- STB  in  1  sample strobe, one CLK wide; latches DACin.
- DACin  in  CHANNELS*W  packed samples, channel c at bits [c*W +: W].
- MUTE  in  1  level; ramps all channels to midscale while high.
- DACout  out  CHANNELS  modulator bitstreams, channel c on bit c.
- MUTED  out  1  high when MUTE=1 and every channel's E equals midscale.

## Operation
- Midscale M = 2^MSBI.
- Input conversion: u = SIGNED_IN ? {~x[MSBI], x[MSBI-1:0]} : x.
- Hold register H[c] (W bits), reset value M. On STB, all H[c] load their u in the same cycle. DACin is ignored when STB=0.
- Target T[c] = MUTE ? M : H[c].
- Ramp tick counter: counts 0..RAMP_DIV-1 and wraps; tick = (count == RAMP_DIV-1). Reset value 0. The counter runs freely and is not restarted by MUTE or STB.
- Effective level E[c] (W bits), reset value M.
  - RAMP_STEP=0: E[c] <= T[c] every clock.
  - Otherwise, on tick only: if |T-E| <= RAMP_STEP then E <= T; else E <= E ± RAMP_STEP toward T.
  - The difference is computed in W+1 bits. E never overshoots T and never wraps past 0 or 2^W-1.
- Modulator per channel: accumulator A[c] is W bits, reset value M.
  - Each clock: {carry, sum} = A + E, computed in W+1 bits; A <= sum; DACout[c] <= carry ^ INV.
  - Mean duty of the carry = E / 2^W. E=0 gives a constant 0 carry. E = 2^W-1 gives a carry on all but 1 of every 2^W clocks; 100% duty is unreachable by design.
- Channels are fully independent except for the shared STB, MUTE and tick.
- MUTED is registered: MUTED <= MUTE & (all E[c] == M), evaluated on the pre-update E values.

## Timing
- Reset (asynchronous assert, synchronous-to-CLK release):
  - DACout = {CHANNELS{INV}}.
  - MUTED = 0.
  - H = E = A = M; tick counter = 0.
- Reset asserted mid-ramp or mid-sample clears all state immediately. No partial state survives.
- STB at edge n: H is valid after n.
  - RAMP_STEP=0: E is updated at n+1, and the first DACout bit affected is registered at n+2.
- STB and MUTE changes in the same cycle: H still loads. T uses the new MUTE value from the next cycle.
- STB during a ramp: the ramp retargets toward the new T from the next tick, with no reset of E.
- MUTE deasserted mid-ramp: E ramps back toward H from its current value.
- MUTED rises one clock after the last E reaches M while MUTE=1. It falls one clock after MUTE drops.

## Test plan
All scenarios use CHANNELS=2, MSBI=3 (W=4, M=8), INV=0 unless stated.
- Reset/idle: hold RESET_N=0, then release with no STB → DACout 0 during reset. Each channel then outputs exactly 8 ones per 16-clock window (E=8); MUTED=0.
- Duty, RAMP_STEP=0: STB with ch0=4, ch1=15 → after 2 clocks, ch0 gives 4 ones and ch1 gives 15 ones per 16 clocks. Loading 0 gives a constant 0.
- Signed input, SIGNED_IN=1, RAMP_STEP=0: STB ch0=4'b1000 (-8), ch1=4'b0111 (+7) → E0=0 and E1=15. Duties are 0/16 and 15/16.
- Soft mute, RAMP_DIV=4, RAMP_STEP=3: from E0=15, assert MUTE → E0 goes 12, 9, 8 on successive ticks (every 4 clocks). MUTED rises one clock after the second channel also reaches 8.
- Retarget: mid-ramp, STB ch0=2 with MUTE dropped → E moves from its current value toward 2 in steps of 3, ending exactly at 2 with no overshoot.
- Async reset mid-ramp, INV=1: drop RESET_N between clock edges → DACout becomes 2'b11 and MUTED becomes 0 immediately. After release, E=8.
